// File: rtl/seq_serializer.sv
// seq_serializer: parallel-to-serial bit feeder for the sequence detector.
// Accepts a word of up to WIDTH bits over a valid/ready handshake. It then
// emits the word one bit per clock on ser_out, qualified by ser_valid, with a
// done pulse on the last bit. Back-to-back words stream with no idle gap.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous, active-high reset
//   load_valid in   load_data/load_len are valid
//   load_ready out  serializer can accept a word this cycle
//   load_data  in   word to serialize (WIDTH bits)
//   load_len   in   bits to send; 0 or >WIDTH means WIDTH
//   ser_out    out  serial bit (registered)
//   ser_valid  out  ser_out carries a word bit (registered)
//   busy       out  word in progress (same as ser_valid)
//   done       out  high while the last bit of a word is on ser_out
module seq_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          LSB_FIRST = 1'b0,
  parameter bit          IDLE_BIT  = 1'b0,
  localparam int unsigned LW       = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic [LW-1:0]    load_len,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             done
);

  localparam logic STATE_IDLE  = 1'b0;
  localparam logic STATE_SHIFT = 1'b1;

  logic             state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [LW-1:0]    rem_q, rem_d;
  logic             ser_out_q, ser_out_d;
  logic             ser_valid_q, ser_valid_d;
  logic             done_q, done_d;

  logic [LW-1:0]    eff_len;
  logic [WIDTH-1:0] aligned;
  logic             accept;

  // Ready in IDLE, or while the last bit is on the wire so the next word
  // follows without a bubble.
  assign load_ready = !reset && ((state_q == STATE_IDLE) || (rem_q == '0));
  assign accept     = load_valid && load_ready;

  always_comb begin
    if ((load_len == '0) || (load_len > LW'(WIDTH))) begin
      eff_len = LW'(WIDTH);
    end else begin
      eff_len = load_len;
    end
  end

  // MSB-first short words are shifted up so the first bit to send always
  // sits at the top of the register; LSB-first words already start at bit 0.
  always_comb begin
    if (LSB_FIRST) begin
      aligned = load_data;
    end else begin
      aligned = load_data << (LW'(WIDTH) - eff_len);
    end
  end

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    rem_d       = rem_q;
    ser_out_d   = ser_out_q;
    ser_valid_d = ser_valid_q;
    done_d      = done_q;
    if (accept) begin
      shreg_d     = aligned;
      ser_out_d   = LSB_FIRST ? aligned[0] : aligned[WIDTH-1];
      ser_valid_d = 1'b1;
      rem_d       = eff_len - LW'(1);
      done_d      = (eff_len == LW'(1));
      state_d     = STATE_SHIFT;
    end else if (state_q == STATE_SHIFT) begin
      if (rem_q != '0) begin
        // The bit currently on ser_out is the register's edge bit; the next
        // one is its neighbour.
        shreg_d   = LSB_FIRST ? (shreg_q >> 1) : (shreg_q << 1);
        ser_out_d = LSB_FIRST ? shreg_q[1] : shreg_q[WIDTH-2];
        rem_d     = rem_q - LW'(1);
        done_d    = (rem_q == LW'(1));
      end else begin
        state_d     = STATE_IDLE;
        shreg_d     = '0;
        ser_out_d   = IDLE_BIT;
        ser_valid_d = 1'b0;
        done_d      = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= STATE_IDLE;
      shreg_q     <= '0;
      rem_q       <= '0;
      ser_out_q   <= IDLE_BIT;
      ser_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      rem_q       <= rem_d;
      ser_out_q   <= ser_out_d;
      ser_valid_q <= ser_valid_d;
      done_q      <= done_d;
    end
  end

  assign ser_out   = ser_out_q;
  assign ser_valid = ser_valid_q;
  assign busy      = ser_valid_q;
  assign done      = done_q;

endmodule
